// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction and data requesters, one transaction in flight.
// Capture to next grant takes 4 cycles for a read and 3 for a write; requesters wait unacked while a transaction is in flight.
package mem_port_arbiter_pkg;
   typedef struct packed {
      logic        valid;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  do_read;
      logic [3:0]  do_write;
   } memory_io_req;

   typedef struct packed {
      logic        valid;
      logic [31:0] data;
   } memory_io_rsp;
endpackage

module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int DATA_PRIORITY = 1,
   parameter int TIMEOUT       = 64
) (
   input  logic         clk,
   input  logic         reset,
   input  memory_io_req inst_req,
   output logic         inst_req_ack,
   output memory_io_rsp inst_rsp,
   input  memory_io_req data_req,
   output logic         data_req_ack,
   output memory_io_rsp data_rsp,
   output memory_io_req mem_req,
   input  logic         mem_req_ack,
   input  memory_io_rsp mem_rsp,
   output logic         timeout_err
);
   localparam logic [1:0]  S_IDLE  = 2'd0;
   localparam logic [1:0]  S_ISSUE = 2'd1;
   localparam logic [1:0]  S_WAIT  = 2'd2;
   localparam logic [1:0]  S_RESP  = 2'd3;
   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

   logic [1:0]   r_state;
   logic         r_last_grant;   // 1 = data; also names the owner of the in-flight transaction
   logic [15:0]  r_cnt;
   memory_io_req r_mem_req;
   memory_io_rsp r_inst_rsp;
   memory_io_rsp r_data_rsp;
   logic         r_timeout_err;

   logic         w_pick_data;
   logic         w_grant;
   logic         w_write_only;
   logic         w_rsp_set;
   logic         w_timeout;
   logic [31:0]  w_rsp_dat;

   always_comb begin
      w_pick_data = data_req.valid;
      if (inst_req.valid && data_req.valid)
         w_pick_data = (DATA_PRIORITY != 0) ? 1'b1 : ~r_last_grant;
      w_grant = reset && (r_state == S_IDLE) && (inst_req.valid || data_req.valid);
   end

   // Read-and-write requests still wait for read data.
   assign w_write_only = (r_mem_req.do_write != 4'd0) && (r_mem_req.do_read == 4'd0);

   always_comb begin
      w_rsp_set = 1'b0;
      w_rsp_dat = '0;
      w_timeout = 1'b0;
      case (r_state)
         S_ISSUE: w_rsp_set = mem_req_ack && w_write_only;
         S_WAIT: begin
            if (mem_rsp.valid) begin
               w_rsp_set = 1'b1;
               w_rsp_dat = mem_rsp.data;
            end else if (r_cnt == TMO_LAST) begin
               w_rsp_set = 1'b1;
               w_timeout = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state       <= S_IDLE;
         r_last_grant  <= 1'b1;
         r_cnt         <= '0;
         r_mem_req     <= '0;
         r_inst_rsp    <= '0;
         r_data_rsp    <= '0;
         r_timeout_err <= 1'b0;
      end else begin
         r_inst_rsp.valid <= w_rsp_set && !r_last_grant;
         r_inst_rsp.data  <= (w_rsp_set && !r_last_grant) ? w_rsp_dat : 32'd0;
         r_data_rsp.valid <= w_rsp_set && r_last_grant;
         r_data_rsp.data  <= (w_rsp_set && r_last_grant) ? w_rsp_dat : 32'd0;
         r_timeout_err    <= w_timeout;
         case (r_state)
            S_IDLE: begin
               if (w_grant) begin
                  r_mem_req    <= w_pick_data ? data_req : inst_req;
                  r_last_grant <= w_pick_data;
                  r_state      <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (mem_req_ack) begin
                  r_mem_req.valid <= 1'b0;
                  r_cnt           <= '0;
                  r_state         <= w_write_only ? S_RESP : S_WAIT;
               end
            end
            S_WAIT: begin
               if (w_rsp_set) r_state <= S_RESP;
               else           r_cnt   <= r_cnt + 16'd1;
            end
            S_RESP:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign inst_req_ack = w_grant && !w_pick_data;
   assign data_req_ack = w_grant && w_pick_data;
   assign mem_req      = r_mem_req;
   assign inst_rsp     = r_inst_rsp;
   assign data_rsp     = r_data_rsp;
   assign timeout_err  = r_timeout_err;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (data priority / TIMEOUT=8, round-robin / TIMEOUT=3)
// checked each cycle against a transaction-level model plus literal expectations.
module tb_mem_port_arbiter;
   import mem_port_arbiter_pkg::*;

   logic         clk = 1'b0;
   logic         rst_n;
   memory_io_req inst_req [2];
   memory_io_req data_req [2];
   memory_io_req mem_req  [2];
   memory_io_rsp inst_rsp [2];
   memory_io_rsp data_rsp [2];
   memory_io_rsp mem_rsp  [2];
   logic         inst_ack [2];
   logic         data_ack [2];
   logic         mem_ack  [2];
   logic         tmo      [2];

   int n_checks = 0;
   int n_errors = 0;
   bit started  = 1'b0;
   int cyc      = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.DATA_PRIORITY(1), .TIMEOUT(8)) dut0 (
      .clk(clk), .reset(rst_n),
      .inst_req(inst_req[0]), .inst_req_ack(inst_ack[0]), .inst_rsp(inst_rsp[0]),
      .data_req(data_req[0]), .data_req_ack(data_ack[0]), .data_rsp(data_rsp[0]),
      .mem_req(mem_req[0]), .mem_req_ack(mem_ack[0]), .mem_rsp(mem_rsp[0]),
      .timeout_err(tmo[0]));

   mem_port_arbiter #(.DATA_PRIORITY(0), .TIMEOUT(3)) dut1 (
      .clk(clk), .reset(rst_n),
      .inst_req(inst_req[1]), .inst_req_ack(inst_ack[1]), .inst_rsp(inst_rsp[1]),
      .data_req(data_req[1]), .data_req_ack(data_ack[1]), .data_rsp(data_rsp[1]),
      .mem_req(mem_req[1]), .mem_req_ack(mem_ack[1]), .mem_rsp(mem_rsp[1]),
      .timeout_err(tmo[1]));

   // Model: one transaction at a time, tracked as captured -> accepted -> answered.
   bit           m_busy [2];
   bit           m_owner[2];   // 1 = data
   bit           m_last [2];
   bit           m_acc  [2];
   bit           m_done [2];
   int           m_wstart[2];
   memory_io_req e_mem  [2];
   memory_io_rsp e_irsp [2];
   memory_io_rsp e_drsp [2];
   bit           e_tmo  [2];

   function automatic int tmo_of(int k);
      return (k == 0) ? 8 : 3;
   endfunction

   // -1 none, 0 instruction, 1 data
   function automatic int winner(int k);
      if (inst_req[k].valid && data_req[k].valid)
         return (k == 0) ? 1 : (m_last[k] ? 0 : 1);
      if (data_req[k].valid) return 1;
      if (inst_req[k].valid) return 0;
      return -1;
   endfunction

   function automatic memory_io_req mk_req(logic [31:0] a, logic [31:0] d, logic [3:0] rd, logic [3:0] wr);
      mk_req = '{valid: 1'b1, addr: a, data: d, do_read: rd, do_write: wr};
   endfunction

   task automatic give(int k, logic [31:0] d);
      if (m_owner[k]) e_drsp[k] = '{valid: 1'b1, data: d};
      else            e_irsp[k] = '{valid: 1'b1, data: d};
   endtask

   task automatic model_step();
      for (int k = 0; k < 2; k++) begin
         int w;
         w = winner(k);
         e_irsp[k] = '0;
         e_drsp[k] = '0;
         e_tmo[k]  = 1'b0;
         if (!rst_n) begin
            m_busy[k] = 1'b0;
            m_last[k] = 1'b1;
            e_mem[k]  = '0;
         end else if (!m_busy[k]) begin
            if (w >= 0) begin
               m_busy[k]  = 1'b1;
               m_owner[k] = (w == 1);
               m_last[k]  = (w == 1);
               e_mem[k]   = (w == 1) ? data_req[k] : inst_req[k];
               m_acc[k]   = 1'b0;
               m_done[k]  = 1'b0;
            end
         end else if (!m_acc[k]) begin
            if (mem_ack[k]) begin
               m_acc[k]       = 1'b1;
               e_mem[k].valid = 1'b0;
               m_wstart[k]    = cyc + 1;
               if (e_mem[k].do_write != 4'd0 && e_mem[k].do_read == 4'd0) begin
                  m_done[k] = 1'b1;
                  give(k, 32'd0);
               end
            end
         end else if (!m_done[k]) begin
            if (mem_rsp[k].valid) begin
               m_done[k] = 1'b1;
               give(k, mem_rsp[k].data);
            end else if (cyc - m_wstart[k] + 1 >= tmo_of(k)) begin
               m_done[k] = 1'b1;
               give(k, 32'd0);
               e_tmo[k] = 1'b1;
            end
         end else begin
            m_busy[k] = 1'b0;
         end
      end
      cyc++;
   endtask

   task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      started = 1'b1;
      #1;
   endtask

   always @(negedge clk) begin
      if (started) begin
         for (int k = 0; k < 2; k++) begin
            int w;
            w = winner(k);
            chk($sformatf("dut%0d inst_req_ack", k), inst_ack[k], rst_n && !m_busy[k] && w == 0);
            chk($sformatf("dut%0d data_req_ack", k), data_ack[k], rst_n && !m_busy[k] && w == 1);
            chk($sformatf("dut%0d mem_req", k),  mem_req[k],  e_mem[k]);
            chk($sformatf("dut%0d inst_rsp", k), inst_rsp[k], e_irsp[k]);
            chk($sformatf("dut%0d data_rsp", k), data_rsp[k], e_drsp[k]);
            chk($sformatf("dut%0d timeout_err", k), tmo[k], e_tmo[k]);
         end
      end
   end

   memory_io_req wreq;
   int           rr_q[$];
   int           rr_exp[4];

   initial begin
      rst_n = 1'b0;
      for (int k = 0; k < 2; k++) begin
         inst_req[k] = '0; data_req[k] = '0; mem_ack[k] = 1'b0; mem_rsp[k] = '0;
      end
      inst_req[0] = mk_req(32'h100, 32'h0, 4'hF, 4'h0);
      tick();
      tick();
      @(negedge clk);
      chk("reset inst_req_ack gated", inst_ack[0], 1'b0);
      chk("reset mem_req zero", mem_req[0], '0);
      chk("reset inst_rsp zero", inst_rsp[0], '0);
      chk("reset timeout_err", tmo[0], 1'b0);

      // Single read on dut0
      tick(); rst_n = 1'b1;
      @(negedge clk);
      chk("read c0 inst_req_ack", inst_ack[0], 1'b1);
      tick(); inst_req[0] = '0; mem_ack[0] = 1'b1;
      @(negedge clk);
      chk("read c1 mem_req.valid", mem_req[0].valid, 1'b1);
      chk("read c1 mem_req.addr", mem_req[0].addr, 32'h100);
      tick(); mem_ack[0] = 1'b0; mem_rsp[0] = '{valid: 1'b1, data: 32'h12345678};
      @(negedge clk);
      chk("read c2 mem_req.valid", mem_req[0].valid, 1'b0);
      tick(); mem_rsp[0] = '0;
      @(negedge clk);
      chk("read c3 inst_rsp", inst_rsp[0], {1'b1, 32'h12345678});
      chk("read c3 data_rsp.valid", data_rsp[0].valid, 1'b0);
      tick();
      @(negedge clk);
      chk("read c4 inst_rsp.valid", inst_rsp[0].valid, 1'b0);

      // Tie with data priority on dut0
      tick();
      inst_req[0] = mk_req(32'h300, 32'h0, 4'hF, 4'h0);
      data_req[0] = mk_req(32'h400, 32'h0, 4'h3, 4'h0);
      mem_ack[0] = 1'b1; mem_rsp[0] = '{valid: 1'b1, data: 32'h0BAD0001};
      @(negedge clk);
      chk("tie c0 data_req_ack", data_ack[0], 1'b1);
      chk("tie c0 inst_req_ack", inst_ack[0], 1'b0);
      tick(); data_req[0] = '0;
      tick();
      tick();
      @(negedge clk);
      chk("tie c3 data_rsp", data_rsp[0], {1'b1, 32'h0BAD0001});
      tick();
      @(negedge clk);
      chk("tie c4 inst_req_ack", inst_ack[0], 1'b1);
      tick(); inst_req[0] = '0;
      repeat (4) tick();
      mem_ack[0] = 1'b0; mem_rsp[0] = '0;

      // Round-robin on dut1, both requesters held for 16 cycles
      inst_req[1] = mk_req(32'h700, 32'h0, 4'hF, 4'h0);
      data_req[1] = mk_req(32'h800, 32'h0, 4'hF, 4'h0);
      mem_ack[1] = 1'b1; mem_rsp[1] = '{valid: 1'b1, data: 32'h55AA0001};
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         if (inst_ack[1]) rr_q.push_back(0);
         if (data_ack[1]) rr_q.push_back(1);
         tick();
      end
      inst_req[1] = '0; data_req[1] = '0; mem_ack[1] = 1'b0; mem_rsp[1] = '0;
      rr_exp = '{0, 1, 0, 1};
      chk("rr grant count", rr_q.size(), 4);
      for (int i = 0; i < 4 && i < rr_q.size(); i++)
         chk($sformatf("rr grant %0d", i), rr_q[i], rr_exp[i]);

      // Write with delayed mem_req_ack on dut0
      tick();
      wreq = mk_req(32'h200, 32'hCAFEF00D, 4'h0, 4'hF);
      data_req[0] = wreq;
      @(negedge clk);
      chk("write c0 data_req_ack", data_ack[0], 1'b1);
      for (int c = 1; c <= 5; c++) begin
         tick();
         data_req[0] = '0;
         mem_ack[0]  = (c == 5);
         mem_rsp[0]  = (c == 3) ? '{valid: 1'b1, data: 32'hFFFF0000} : '0;
         @(negedge clk);
         chk($sformatf("write c%0d mem_req held", c), mem_req[0], wreq);
      end
      tick(); mem_ack[0] = 1'b0;
      @(negedge clk);
      chk("write c6 data_rsp", data_rsp[0], {1'b1, 32'h0});

      // Timeout on dut0 (TIMEOUT=8)
      tick();
      inst_req[0] = mk_req(32'h500, 32'h0, 4'hF, 4'h0);
      @(negedge clk);
      chk("tmo c0 inst_req_ack", inst_ack[0], 1'b1);
      tick(); inst_req[0] = '0; mem_ack[0] = 1'b1;
      tick(); mem_ack[0] = 1'b0;
      for (int c = 2; c < 10; c++) begin
         @(negedge clk);
         chk($sformatf("tmo c%0d quiet", c), {tmo[0], inst_rsp[0].valid}, 2'b00);
         tick();
      end
      @(negedge clk);
      chk("tmo c10 inst_rsp", inst_rsp[0], {1'b1, 32'h0});
      chk("tmo c10 timeout_err", tmo[0], 1'b1);
      tick(); mem_rsp[0] = '{valid: 1'b1, data: 32'hDEADBEEF};
      @(negedge clk);
      chk("tmo c11 pulse ended", {tmo[0], inst_rsp[0].valid}, 2'b00);
      tick(); mem_rsp[0] = '0;
      @(negedge clk);
      chk("tmo c12 stray ignored", inst_rsp[0].valid, 1'b0);

      // Reset while in WAIT on dut0
      tick();
      inst_req[0] = mk_req(32'h600, 32'h0, 4'hF, 4'h0);
      tick(); inst_req[0] = '0; mem_ack[0] = 1'b1;
      tick(); mem_ack[0] = 1'b0;
      tick(); rst_n = 1'b0;
      tick(); rst_n = 1'b1;
      mem_rsp[0]  = '{valid: 1'b1, data: 32'h12121212};
      data_req[0] = mk_req(32'h900, 32'h0, 4'hF, 4'h0);
      @(negedge clk);
      chk("rst mid mem_req zero", mem_req[0], '0);
      chk("rst mid idle grant", data_ack[0], 1'b1);
      tick(); data_req[0] = '0; mem_rsp[0] = '0; mem_ack[0] = 1'b1;
      tick(); mem_ack[0] = 1'b0; mem_rsp[0] = '{valid: 1'b1, data: 32'h00000077};
      tick(); mem_rsp[0] = '0;
      @(negedge clk);
      chk("rst mid data_rsp", data_rsp[0], {1'b1, 32'h77});
      for (int c = 0; c < 4; c++) begin
         tick();
         @(negedge clk);
         chk("rst mid no inst_rsp", inst_rsp[0].valid, 1'b0);
      end

      tick();
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
